// File: rtl/mult_add_pkg.sv
// Shared definitions for the 4-lane mult-add primitive and its consumers:
// widths, result/accumulator/output types and the saturating requantiser.
package mult_add_pkg;

  localparam int MAC_RES_W = 26;
  localparam int MAC_LANES = 4;
  localparam int MAC_LAT   = 3;
  localparam int ACC_W     = 32;
  localparam int Q_W       = 8;

  typedef logic signed [MAC_RES_W-1:0] mac_result_t;
  typedef logic signed [ACC_W-1:0]     acc_t;
  typedef logic signed [Q_W-1:0]       q8_t;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic signed [ACC_W:0] Q_MAX   = (ACC_W+1)'(2**(Q_W-1) - 1);
  localparam logic signed [ACC_W:0] Q_MIN   = ~Q_MAX;
  localparam logic signed [ACC_W:0] WIDE_ONE = (ACC_W+1)'(1);

  // Round-half-up, arithmetic shift, clamp to the signed Q_W range.
  // One guard bit keeps acc + rounding constant from overflowing.
  function automatic q8_t requant(input acc_t acc, input logic [4:0] shift);
    logic signed [ACC_W:0] wide;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] r;
    wide = {acc[ACC_W-1], acc};
    rnd  = (shift != 5'd0) ? (WIDE_ONE << (shift - 5'd1)) : '0;
    r    = (wide + rnd) >>> shift;
    if (r > Q_MAX)      r = Q_MAX;
    else if (r < Q_MIN) r = Q_MIN;
    return r[Q_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO with occupancy count; concurrent
// write and read are legal at any occupancy, including full and empty.
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock0,
  input  logic                     sclr0,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign count   = wr_ptr - rd_ptr;
  assign valid   = (count != '0);
  assign rd_data = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clock0) begin
    if (sclr0) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en)          wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && valid) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; only the pointers are, and
  // rd_data is forced to zero while empty so stale entries never show.
  always_ff @(posedge clock0) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mult_add_acc_requant.sv
// Consumer for the mult-add primitive: tracks issued beats through MAC_LAT,
// accumulates cfg_len results per output, requantises to 8 bits and queues
// outputs in a credit-protected FWFT FIFO.
module mult_add_acc_requant #(
  parameter int IN_W       = 26,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 8,
  parameter int MAC_LAT    = 3,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clock0,
  input  logic                    sclr0,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic [LEN_W-1:0]        cfg_num_out,
  input  logic [4:0]              cfg_shift,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic signed [IN_W-1:0]  result,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  import mult_add_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t                  state;
  logic [LEN_W-1:0]        len_q, num_q;
  logic [4:0]              shift_q;
  logic [LEN_W-1:0]        iss_beat, iss_out, grp_cnt, out_cnt;
  logic [MAC_LAT-1:0]      vld_dly;
  logic signed [ACC_W-1:0] acc;
  logic                    acc_vld;
  logic [OUT_W-1:0]        q_data;
  logic                    q_vld;
  logic [CNT_W-1:0]        inflight, fifo_count, credits;
  logic                    accept, last_beat, sample, last_sample, pop;

  // Credits cover both queued outputs and groups whose last beat has issued.
  assign credits     = CNT_W'(FIFO_DEPTH) - fifo_count - inflight;
  assign issue_ready = (state == ST_RUN) && (credits != '0) && (iss_out < num_q);
  assign accept      = issue_valid && issue_ready;
  assign last_beat   = (iss_beat == len_q - ONE);
  assign sample      = vld_dly[MAC_LAT-1];
  assign last_sample = (grp_cnt == len_q - ONE);
  assign pop         = out_valid && out_ready;
  assign busy        = (state == ST_RUN);
  assign done        = (state == ST_RUN) && pop && (out_cnt == num_q - ONE);

  always_ff @(posedge clock0) begin
    if (sclr0) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      num_q    <= '0;
      shift_q  <= '0;
      iss_beat <= '0;
      iss_out  <= '0;
      grp_cnt  <= '0;
      out_cnt  <= '0;
      vld_dly  <= '0;
      acc      <= '0;
      acc_vld  <= 1'b0;
      q_data   <= '0;
      q_vld    <= 1'b0;
      inflight <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && cfg_len != '0 && cfg_num_out != '0) begin
            state    <= ST_RUN;
            len_q    <= cfg_len;
            num_q    <= cfg_num_out;
            shift_q  <= cfg_shift;
            iss_beat <= '0;
            iss_out  <= '0;
            grp_cnt  <= '0;
            out_cnt  <= '0;
          end
        end
        ST_RUN:  if (done) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        if (last_beat) begin
          iss_beat <= '0;
          iss_out  <= iss_out + ONE;
        end else begin
          iss_beat <= iss_beat + ONE;
        end
      end
      if (pop) out_cnt <= out_cnt + ONE;

      case ({accept && last_beat, q_vld})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase

      vld_dly <= (vld_dly << 1) | MAC_LAT'(accept);

      acc_vld <= sample && last_sample;
      if (sample) begin
        if (grp_cnt == '0) acc <= {{(ACC_W-IN_W){result[IN_W-1]}}, result};
        else               acc <= acc + {{(ACC_W-IN_W){result[IN_W-1]}}, result};
        grp_cnt <= last_sample ? '0 : grp_cnt + ONE;
      end

      // NOTE: nonblocking update lets requant read the finished sum on the
      // same edge that the next group's first result reloads acc.
      q_vld <= acc_vld;
      if (acc_vld) q_data <= requant(acc, shift_q);
    end
  end

  sync_fifo_fwft #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock0  (clock0),
    .sclr0   (sclr0),
    .wr_en   (q_vld),
    .wr_data (q_data),
    .rd_en   (pop),
    .rd_data (out_data),
    .valid   (out_valid),
    .count   (fifo_count)
  );

endmodule

// File: doc/mult_add_acc_requant.md
Name: mult_add_acc_requant

Overview:
- Consumer-side companion to the 4-lane 8b x 16b fixed-point mult-add primitive.
- Tracks the feeder's issue beats through the primitive's fixed pipeline latency.
- Accumulates cfg_len consecutive 26-bit dot-product results per output.
- Requantises each accumulated sum to signed 8 bits (round, shift, saturate) and streams it out through a credit-protected output FIFO with valid/ready.
- Sits between the Winograd/conv MAC array and the output/pooling writer.

Parameters:
- IN_W, 26, width of the mult-add result (signed).
- ACC_W, 32, accumulator width; no overflow for cfg_len up to 2^(ACC_W-IN_W)=64.
- OUT_W, 8, requantised output width (signed).
- MAC_LAT, 3, clock0 cycles from operands applied to result valid on the primitive.
- LEN_W, 16, width of the cfg_len and cfg_num_out counters.
- FIFO_DEPTH, 4, output FIFO entries (power of 2, at least 2).

Ports:
- clock0  in  1  clock.
- sclr0  in  1  synchronous active-high reset.
- start  in  1  one-cycle job start; samples cfg_*.
- cfg_len  in  LEN_W  results accumulated per output.
- cfg_num_out  in  LEN_W  outputs per job.
- cfg_shift  in  5  arithmetic right shift for requantisation.
- issue_valid  in  1  feeder presents operands to the mult-add this cycle.
- issue_ready  out  1  block can accept an issue beat.
- result  in  IN_W  mult-add result, signed.
- out_data  out  OUT_W  requantised value.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: on sclr0 high at a clock0 edge, all of the following take effect and in-flight results are discarded:
  - state = IDLE; busy, done, out_valid, issue_ready = 0; out_data = 0.
  - FIFO emptied; counters, accumulator, credits and valid delay line cleared.
  - sclr0 has priority over every other input.
- FSM IDLE:
  - start=1 with cfg_len!=0 and cfg_num_out!=0 latches cfg_* and moves to RUN; busy=1 from the next cycle.
  - start with any zero field is ignored.
- FSM RUN:
  - start is ignored.
  - Leaves to IDLE on the cycle the final output handshake (out_valid & out_ready) completes.
  - done=1 for exactly that cycle; busy=0 from the next cycle.
- Issue accept: beat accepted = issue_valid & issue_ready.
  - issue_ready = (state==RUN) & (credits!=0) & (issued_outputs < cfg_num_out).
  - Beats presented while issue_ready=0 are not tracked; the feeder must hold its operands.
- Credits:
  - credits = FIFO_DEPTH - fifo_count - outputs_in_flight.
  - An output is in flight from the accept of its group's last issue beat until its FIFO write.
  - Simultaneous FIFO pop and group completion net to zero change.
- Alignment: an accepted beat in cycle t is delayed MAC_LAT cycles; result is sampled in cycle t+MAC_LAT. result is ignored when the delayed flag is 0.
- Accumulate:
  - The first sampled result of a group loads the accumulator with result sign-extended to ACC_W.
  - Later results add to it.
  - Sums beyond ACC_W wrap modulo 2^ACC_W; this is the documented limit for cfg_len > 64.
  - The group counter wraps to 0 after cfg_len results.
- Requant (one register stage):
  - r = (acc + (cfg_shift!=0 ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift, computed at ACC_W+1 bits with no overflow.
  - Saturate to [-128, 127], then write to the FIFO.
- Latency: the last issue beat of a group in cycle t gives out_valid=1 in cycle t+MAC_LAT+3 when the FIFO is empty and the output is not stalled.
- Output:
  - FIFO is first-word fall-through.
  - out_data is held stable while out_valid & !out_ready.
  - Pop occurs on out_valid & out_ready.
- Simultaneous FIFO write and pop are supported at any occupancy, including full and empty.

Decomposition:
- Shared package mult_add_pkg:
  - constants MAC_RES_W=26, MAC_LANES=4, MAC_LAT=3, ACC_W=32, Q_W=8.
  - typedefs mac_result_t, acc_t, q8_t.
  - saturating-requant function.
- One natural sub-module: sync_fifo_fwft (parameterised width/depth, count output). The requant function is shared with the golden model.

Test Plan:
- cfg_len=4, cfg_num_out=1, cfg_shift=2; results 100,200,-50,7 (sum 257) -> out_data=64 (257+2>>2); out_valid exactly MAC_LAT+3 cycles after the 4th issue beat; done pulses on the handshake.
- Saturation: cfg_len=1, cfg_shift=0, results 300 and -300 with cfg_num_out=2 -> outputs 127 then -128. Rounding: result -6, cfg_shift=2 -> -1.
- Backpressure: cfg_len=1, cfg_num_out=8, out_ready=0 -> exactly 4 beats accepted, then issue_ready=0. Release out_ready -> 8 outputs in order with no loss or duplication.
- Wrap: cfg_len=65, every result = 2^25-1 -> acc wraps modulo 2^32. Output matches the golden model using the identical modulo rule.
- Reset mid-job: sclr0 asserted 2 cycles after the 3rd of 4 beats -> next cycle busy=0, out_valid=0, issue_ready=0. A new start produces only new-job outputs.
- Ignored starts: start with cfg_len=0 -> busy stays 0. start during RUN -> cfg_* unchanged and the current job completes normally.
